alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command-side controller for the 4-bit ALU datapath.
//
// A command (op, A, B) is accepted over a valid/ready handshake. It is
// registered onto alu_op/alu_a/alu_b and held for EXEC_CYCLES cycles. The
// combinational datapath result is then captured and returned with status
// flags over a second valid/ready handshake. Only one command is in flight
// at a time.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. A source holds valid and its data stable until that edge.
// rsp_valid/rsp_r/rsp_flags stay stable from the rise of rsp_valid until
// the edge that completes the transfer.
//
// Optional feature: define ALU_ISSUE_CTRL_ACC_EN to add a 4-bit accumulator.
// The accumulator loads every captured result. A command with cmd_acc = 1
// then takes operand A from the accumulator. Without the macro, cmd_acc is
// ignored. The port list is the same in both builds.
//
// The FSM state register is the signal 'state' (type state_t), so checkers
// can bind to it directly.

module alu_issue_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1  // settle cycles, legal 1..15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_acc,
  output logic [2:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_r,
  input  logic       alu_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_r,
  output logic [2:0] rsp_flags
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;
  logic [3:0] operand_a;

  // Handshake strobes are decoded from the state register only.
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid & cmd_ready;
  assign capture   = (state == EXEC) && (cnt == 4'd0);

`ifdef ALU_ISSUE_CTRL_ACC_EN
  logic [3:0] acc;

  // The accumulator follows every captured result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= 4'd0;
    end else if (capture) begin
      acc <= alu_r;
    end
  end

  assign operand_a = cmd_acc ? acc : cmd_a;
`else
  logic unused_cmd_acc;

  assign unused_cmd_acc = cmd_acc;
  assign operand_a      = cmd_a;
`endif

  // Register the FSM state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Select the next state from the handshakes and the settle counter.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)    state_next = EXEC;
      EXEC: if (capture)   state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Load the datapath operands on accept and count down the settle time.
  // The operands hold their values in every other cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_op <= 3'd0;
      alu_a  <= 4'd0;
      alu_b  <= 4'd0;
      cnt    <= 4'd0;
    end else if (accept) begin
      alu_op <= cmd_op;
      alu_a  <= operand_a;
      alu_b  <= cmd_b;
      cnt    <= CNT_LOAD;
    end else if ((state == EXEC) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Capture the result and derive the flags {carry, sign, zero}.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_r     <= 4'd0;
      rsp_flags <= 3'd0;
    end else if (capture) begin
      rsp_r     <= alu_r;
      rsp_flags <= {alu_cout, alu_r[3], (alu_r == 4'd0)};
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl.
// dut1 uses EXEC_CYCLES = 1 and dut4 uses EXEC_CYCLES = 4. Both share one
// clock. Each datapath stub computes {cout, r} = a + b.

module tb_alu_issue_ctrl;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset_n1;
  logic reset_n4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- dut1 (EXEC_CYCLES = 1) ----------------
  logic       cmd_valid1, cmd_ready1, cmd_acc1, rsp_valid1, rsp_ready1, alu_cout1;
  logic [2:0] cmd_op1, alu_op1, rsp_flags1;
  logic [3:0] cmd_a1, cmd_b1, alu_a1, alu_b1, alu_r1, rsp_r1;

  assign {alu_cout1, alu_r1} = {1'b0, alu_a1} + {1'b0, alu_b1};

  alu_issue_ctrl #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n1),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_acc(cmd_acc1),
    .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_r(alu_r1), .alu_cout(alu_cout1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_r(rsp_r1), .rsp_flags(rsp_flags1)
  );

  // ---------------- dut4 (EXEC_CYCLES = 4) ----------------
  logic       cmd_valid4, cmd_ready4, cmd_acc4, rsp_valid4, rsp_ready4, alu_cout4;
  logic [2:0] cmd_op4, alu_op4, rsp_flags4;
  logic [3:0] cmd_a4, cmd_b4, alu_a4, alu_b4, alu_r4, rsp_r4;

  assign {alu_cout4, alu_r4} = {1'b0, alu_a4} + {1'b0, alu_b4};

  alu_issue_ctrl #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .reset_n(reset_n4),
    .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_op(cmd_op4),
    .cmd_a(cmd_a4), .cmd_b(cmd_b4), .cmd_acc(cmd_acc4),
    .alu_op(alu_op4), .alu_a(alu_a4), .alu_b(alu_b4),
    .alu_r(alu_r4), .alu_cout(alu_cout4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
    .rsp_r(rsp_r4), .rsp_flags(rsp_flags4)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Compare rsp_r of dut1 against the oldest expected result.
  task automatic expect_rsp1(input string tag);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: response with no expected entry, got %0d", tag, rsp_r1);
    end else begin
      check(tag, {4'd0, rsp_r1}, {4'd0, exp_q.pop_front()});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one dut1 command with rsp_ready high and check the whole transaction.
  task automatic issue1(input string tag, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic acc, input logic [3:0] exp_a,
                        input logic [3:0] exp_r, input logic [2:0] exp_flags);
    int n;
    cmd_op1 = op; cmd_a1 = a; cmd_b1 = b; cmd_acc1 = acc;
    cmd_valid1 = 1'b1; rsp_ready1 = 1'b1;
    check({tag, "_ready"}, {7'd0, cmd_ready1}, 8'd1);
    exp_q.push_back(exp_r);
    tick();
    cmd_valid1 = 1'b0; cmd_acc1 = 1'b0;
    check({tag, "_alu_a"}, {4'd0, alu_a1}, {4'd0, exp_a});
    n = 1;
    while (!rsp_valid1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n[7:0], 8'd2);
    expect_rsp1({tag, "_rsp_r"});
    check({tag, "_flags"}, {5'd0, rsp_flags1}, {5'd0, exp_flags});
    tick();
    check({tag, "_back_idle"}, {7'd0, cmd_ready1}, 8'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset_n1 = 1'b0; reset_n4 = 1'b0;
    cmd_valid1 = 0; cmd_op1 = 0; cmd_a1 = 0; cmd_b1 = 0; cmd_acc1 = 0; rsp_ready1 = 0;
    cmd_valid4 = 0; cmd_op4 = 0; cmd_a4 = 0; cmd_b4 = 0; cmd_acc4 = 0; rsp_ready4 = 0;
    tick();
    tick();

    // Values held in reset
    check("rst_cmd_ready", {7'd0, cmd_ready1}, 8'd1);
    check("rst_rsp_valid", {7'd0, rsp_valid1}, 8'd0);
    check("rst_rsp_r",     {4'd0, rsp_r1}, 8'd0);
    check("rst_rsp_flags", {5'd0, rsp_flags1}, 8'd0);
    check("rst_alu_op",    {5'd0, alu_op1}, 8'd0);
    check("rst_alu_a",     {4'd0, alu_a1}, 8'd0);
    check("rst_alu_b",     {4'd0, alu_b1}, 8'd0);
    reset_n1 = 1'b1; reset_n4 = 1'b1;
    tick();

    // Single command: op 4, 9 + 8 -> r = 1, carry
    cmd_op1 = 3'b100; cmd_a1 = 4'd9; cmd_b1 = 4'd8; cmd_valid1 = 1'b1; rsp_ready1 = 1'b1;
    check("c0_cmd_ready", {7'd0, cmd_ready1}, 8'd1);
    exp_q.push_back(4'd1);
    tick();
    cmd_valid1 = 1'b0;
    check("c1_alu_op", {5'd0, alu_op1}, 8'd4);
    check("c1_alu_a",  {4'd0, alu_a1}, 8'd9);
    check("c1_alu_b",  {4'd0, alu_b1}, 8'd8);
    check("c1_cmd_ready", {7'd0, cmd_ready1}, 8'd0);
    check("c1_rsp_valid", {7'd0, rsp_valid1}, 8'd0);
    tick();
    check("c2_rsp_valid", {7'd0, rsp_valid1}, 8'd1);
    expect_rsp1("c2_rsp_r");
    check("c2_flags", {5'd0, rsp_flags1}, 8'b100);
    tick();
    check("c3_cmd_ready", {7'd0, cmd_ready1}, 8'd1);
    check("c3_rsp_valid", {7'd0, rsp_valid1}, 8'd0);

    // Backpressure: 8 + 8 -> r = 0, flags carry|zero. A second command waits.
    rsp_ready1 = 1'b0;
    cmd_op1 = 3'b000; cmd_a1 = 4'd8; cmd_b1 = 4'd8; cmd_valid1 = 1'b1;
    exp_q.push_back(4'd0);
    tick();
    cmd_a1 = 4'd4; cmd_b1 = 4'd4;  // second command offered and held
    tick();
    check("bp_rsp_valid", {7'd0, rsp_valid1}, 8'd1);
    expect_rsp1("bp_rsp_r");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", {7'd0, rsp_valid1}, 8'd1);
      check("bp_hold_r", {4'd0, rsp_r1}, 8'd0);
      check("bp_hold_flags", {5'd0, rsp_flags1}, 8'b101);
      check("bp_no_accept", {7'd0, cmd_ready1}, 8'd0);
      check("bp_alu_a_held", {4'd0, alu_a1}, 8'd8);
      tick();
    end
    rsp_ready1 = 1'b1;
    tick();
    check("bp_done_valid", {7'd0, rsp_valid1}, 8'd0);
    check("bp_done_ready", {7'd0, cmd_ready1}, 8'd1);
    exp_q.push_back(4'd8);
    tick();
    cmd_valid1 = 1'b0;
    check("c2nd_alu_a", {4'd0, alu_a1}, 8'd4);
    tick();
    check("c2nd_rsp_valid", {7'd0, rsp_valid1}, 8'd1);
    expect_rsp1("c2nd_rsp_r");
    check("c2nd_flags", {5'd0, rsp_flags1}, 8'b010);
    tick();

    // Accumulator chaining; without the macro operand A comes from cmd_a
    issue1("acc1", 3'b000, 4'd3, 4'd4, 1'b0, 4'd3, 4'd7, 3'b000);
`ifdef ALU_ISSUE_CTRL_ACC_EN
    issue1("acc2", 3'b000, 4'd15, 4'd2, 1'b1, 4'd7, 4'd9, 3'b010);
`else
    issue1("acc2", 3'b000, 4'd15, 4'd2, 1'b1, 4'd15, 4'd1, 3'b100);
`endif

    // EXEC_CYCLES = 4: 3 + 2 held for cycles 1..4, response in cycle 5
    cmd_op4 = 3'b001; cmd_a4 = 4'd3; cmd_b4 = 4'd2; cmd_valid4 = 1'b1; rsp_ready4 = 1'b1;
    tick();
    cmd_valid4 = 1'b0; cmd_a4 = 4'd0; cmd_b4 = 4'd0;
    for (int i = 1; i <= 4; i++) begin
      check("e4_alu_op", {5'd0, alu_op4}, 8'd1);
      check("e4_alu_a", {4'd0, alu_a4}, 8'd3);
      check("e4_alu_b", {4'd0, alu_b4}, 8'd2);
      check("e4_no_rsp", {7'd0, rsp_valid4}, 8'd0);
      tick();
    end
    check("e4_rsp_valid", {7'd0, rsp_valid4}, 8'd1);
    check("e4_rsp_r", {4'd0, rsp_r4}, 8'd5);
    check("e4_flags", {5'd0, rsp_flags4}, 8'd0);
    tick();
    check("e4_back_idle", {7'd0, cmd_ready4}, 8'd1);

    // Reset in cycle 2 of EXEC discards the command
    cmd_a4 = 4'd7; cmd_b4 = 4'd6; cmd_valid4 = 1'b1;
    tick();
    cmd_valid4 = 1'b0;
    tick();
    reset_n4 = 1'b0;
    #1;
    check("mr_cmd_ready", {7'd0, cmd_ready4}, 8'd1);
    check("mr_rsp_valid", {7'd0, rsp_valid4}, 8'd0);
    check("mr_alu_a", {4'd0, alu_a4}, 8'd0);
    check("mr_alu_b", {4'd0, alu_b4}, 8'd0);
    check("mr_alu_op", {5'd0, alu_op4}, 8'd0);
    check("mr_rsp_r", {4'd0, rsp_r4}, 8'd0);
    tick();
    tick();
    reset_n4 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("mr_no_rsp", {7'd0, rsp_valid4}, 8'd0);
      tick();
    end
    cmd_a4 = 4'd6; cmd_b4 = 4'd7; cmd_valid4 = 1'b1;
    tick();
    cmd_valid4 = 1'b0;
    n = 1;
    while (!rsp_valid4 && n < 20) begin
      tick();
      n++;
    end
    check("mr_next_latency", n[7:0], 8'd5);
    check("mr_next_r", {4'd0, rsp_r4}, 8'd13);
    check("mr_next_flags", {5'd0, rsp_flags4}, 8'b010);
    tick();

    check("exp_q_drained", exp_q.size() == 0 ? 8'd1 : 8'd0, 8'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
